// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall sequencer: stall bus,
// controller state encodings and the priority-ordered stall patterns.
package pipe_stall_ctrl_pkg;

    typedef logic [5:0] StallBus;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam logic [1:0] CTRL_RUN      = 2'd0;
    localparam logic [1:0] CTRL_DIV_WAIT = 2'd1;
    localparam logic [1:0] CTRL_DIV_DONE = 2'd2;

    // Bit 0 PC ... bit 5 WB; the first non-stopped stage receives the bubble.
    localparam StallBus STALL_MEM   = {NoStop, {5{Stop}}};
    localparam StallBus STALL_DIV   = {{2{NoStop}}, {4{Stop}}};
    localparam StallBus STALL_LDUSE = {{3{NoStop}}, {3{Stop}}};
    localparam StallBus STALL_NONE  = {6{NoStop}};

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Bundle between the stall sequencer and the ID/EX/MEM stages plus divider.
// slave is the sequencer side; master is the pipeline/divider side.
interface pipe_stall_ctrl_if;
    import pipe_stall_ctrl_pkg::*;

    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       ex_is_load;
    logic [4:0] ex_rf_waddr;
    logic       ex_div_req;
    logic       div_ready;
    logic       mem_stallreq;
    StallBus    stall;
    logic       div_go;
    logic       div_busy;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, ex_is_load, ex_rf_waddr,
               ex_div_req, div_ready, mem_stallreq,
        input  stall, div_go, div_busy
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, ex_is_load, ex_rf_waddr,
               ex_div_req, div_ready, mem_stallreq,
        output stall, div_go, div_busy
    );

endinterface

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
// Increments by one on each enabled cycle and holds at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] q
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign q = r_cnt;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall sequencer: merges load-use, divider and data-SRAM stalls.
// stall/div_go are combinational (0-cycle latency); mem_stallreq always wins.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    pipe_stall_ctrl_if.slave bus,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    StallBus    w_stall;
    logic       w_div_go;
    logic       w_rs_hit;
    logic       w_rt_hit;
    logic       w_ld_use;

    always_comb begin
        w_rs_hit = bus.id_use_rs && (bus.id_rs == bus.ex_rf_waddr);
        w_rt_hit = bus.id_use_rt && (bus.id_rt == bus.ex_rf_waddr);
        w_ld_use = bus.ex_is_load && (bus.ex_rf_waddr != 5'd0) && (w_rs_hit || w_rt_hit);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = STALL_NONE;
        w_div_go    = 1'b0;
        case (r_state)
            CTRL_RUN: begin
                // A divide blocked by a memory wait stays in EX and retries next cycle.
                if (bus.ex_div_req) begin
                    if (!bus.mem_stallreq) begin
                        w_stall     = STALL_DIV;
                        w_div_go    = 1'b1;
                        w_state_nxt = CTRL_DIV_WAIT;
                    end
                end else if (w_ld_use) begin
                    w_stall = STALL_LDUSE;
                end
            end
            CTRL_DIV_WAIT: begin
                if (bus.div_ready) begin
                    w_state_nxt = bus.mem_stallreq ? CTRL_DIV_DONE : CTRL_RUN;
                end else begin
                    w_stall = STALL_DIV;
                end
            end
            CTRL_DIV_DONE: begin
                if (!bus.mem_stallreq) begin
                    w_state_nxt = CTRL_RUN;
                end
            end
            default: begin
                w_state_nxt = CTRL_RUN;
            end
        endcase
        if (bus.mem_stallreq) begin
            w_stall = STALL_MEM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CTRL_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign bus.stall    = w_stall;
    assign bus.div_go   = w_div_go;
    assign bus.div_busy = (r_state == CTRL_DIV_WAIT);

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .en  (w_stall[0]),
        .q   (stall_cnt)
    );

endmodule
